// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // Write-data source encodings on wb_sel
    localparam logic [1:0] WB_SEL_PC4  = 2'd0;
    localparam logic [1:0] WB_SEL_ALU  = 2'd1;
    localparam logic [1:0] WB_SEL_MEM  = 2'd2;
    localparam logic [1:0] WB_SEL_ZERO = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    // One buffered MDU result
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_ent_t;

    function automatic logic [XLEN-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [XLEN-1:0] v;
        v     = '0;
        v[rd] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Register FIFO holding MDU results (rd + data) awaiting a register-file write slot.
// Latency: a pushed entry appears at the head/valid outputs the cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty; caller gates with full/empty.
//
// Ports: clk/rstn, push + push_ent, pop, head entry, count/full/empty,
//        per-entry valid and rd for the pending-register mask decode.
module wb_pend_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                push,
    input  wb_ent_t                             push_ent,
    input  logic                                pop,
    output wb_ent_t                             head,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                full,
    output logic                                empty,
    output logic [DEPTH-1:0]                    ent_vld,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_ent_t [DEPTH-1:0] mem_q, mem_d;
    logic    [DEPTH-1:0] vld_q, vld_d;
    logic    [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic    [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic    [CW-1:0]    count_q, count_d;

    logic push_ok;
    logic pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        // Push and pop never touch the same slot: a pop needs a live entry,
        // a push needs a free one, so the pointers differ whenever both fire.
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_ent;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // wraps naturally, DEPTH is a power of two
        end
        if (pop_ok) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q    <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_rd[i] = mem_q[i].rd;
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign ent_vld = vld_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB stage and buffered MDU results.
// Latency: pipeline write is combinational (0 cycles); an MDU result is written no earlier than 1 cycle after enqueue.
// Backpressure: mdu_ready drops when the buffer is full; after STARVE_LIMIT blocked cycles stall_o freezes the pipeline for one cycle.
//
// Ports: clk/rstn; pipeline WB request (wb_en, wb_rd, wb_sel) with its three data sources;
//        MDU valid/ready result channel (mdu_rd, mdu_data); stall_o to the pipeline;
//        rf_we/rf_wa/rf_wd to the register file; pend_mask to the hazard unit.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [1:0]            wb_sel,
    input  logic [XLEN-1:0]       pc_add4,
    input  logic [XLEN-1:0]       alu_res,
    input  logic [XLEN-1:0]       dmem_rdata,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_data,
    output logic                  mdu_ready,
    output logic                  stall_o,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wa,
    output logic [XLEN-1:0]       rf_wd,
    output logic [XLEN-1:0]       pend_mask
);

    localparam int CW = $clog2(DEPTH) + 1;

    arb_state_e state_q, state_d;
    logic [3:0] starve_q, starve_d;

    wb_ent_t                          push_ent;
    wb_ent_t                          head;
    logic [CW-1:0]                    fifo_count;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic [DEPTH-1:0]                 ent_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;

    logic            push;
    logic            pop;
    logic            slot_free;
    logic [CW-1:0]   count_after_pop;
    logic [XLEN-1:0] wb_data;

    // A zero-rd MDU result completes its handshake but is dropped here.
    assign mdu_ready = ~fifo_full;
    assign push      = mdu_valid & mdu_ready & (mdu_rd != '0);
    assign push_ent  = '{rd: mdu_rd, data: mdu_data};

    // Writes to x0 never reach the register file, so they leave the slot free.
    assign slot_free = ~wb_en | (wb_rd == '0);

    // FORCE drains unconditionally; WAIT drains only into a free slot.
    assign pop = ~fifo_empty & ((state_q == FORCE) | ((state_q == WAIT) & slot_free));

    // Occupancy once the current pop and push both land; only meaningful when pop = 1.
    assign count_after_pop = fifo_count - CW'(1) + CW'(push);

    wb_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_ent (push_ent),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .ent_vld  (ent_vld),
        .ent_rd   (ent_rd)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                starve_d = '0;
                if (push) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (pop) begin
                    starve_d = '0;
                    if (count_after_pop == '0) begin
                        state_d = IDLE;
                    end
                end else begin
                    starve_d = starve_q + 4'd1;
                    if (starve_d >= 4'(STARVE_LIMIT)) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                starve_d = '0;
                state_d  = (count_after_pop == '0) ? IDLE : WAIT;
            end
            default: begin
                state_d  = IDLE;
                starve_d = '0;
            end
        endcase
    end

    // Pipeline write-data source select
    always_comb begin
        case (wb_sel)
            WB_SEL_PC4:  wb_data = pc_add4;
            WB_SEL_ALU:  wb_data = alu_res;
            WB_SEL_MEM:  wb_data = dmem_rdata;
            default:     wb_data = '0;
        endcase
    end

    // Output logic. rstn gates rf_we directly so the pipeline cannot write
    // while reset is held, independent of any clock edge.
    always_comb begin
        rf_we   = 1'b0;
        rf_wa   = '0;
        rf_wd   = '0;
        stall_o = (state_q == FORCE);
        if (rstn) begin
            if (pop) begin
                rf_we = 1'b1;
                rf_wa = head.rd;
                rf_wd = head.data;
            end else if (!slot_free) begin
                rf_we = 1'b1;
                rf_wa = wb_rd;
                rf_wd = wb_data;
            end
        end
    end

    // Pending-destination mask: a bit stays set while any live entry targets it,
    // so duplicate rd entries keep it high until the last one drains.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                pend_mask = pend_mask | rd_onehot(ent_rd[i]);
            end
        end
        pend_mask[0] = 1'b0;
    end

endmodule
